// File: rtl/caesar_stream_ctrl.sv
// caesar_stream_ctrl
// Pulls a ciphertext byte stream over valid/ready after a start command,
// deciphers each byte (t3=c^k; t2=t3^(t3>>4); t1=t2-k; p=t1^k, all mod 256),
// buffers the plaintext in a small FIFO and streams it out over valid/ready.
//
// Optional feature macro: KEY_ROTATE_EN
//   defined   : key register rotates left by one after every accepted byte
//   undefined : key register stays constant for the whole message
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      command strobe, only honoured in IDLE
//   key_in     key, latched on accepted start
//   msg_len    message length in bytes, latched on accepted start
//   in_valid   ciphertext byte available
//   in_data    ciphertext byte
//   in_ready   controller accepts in_data this cycle
//   out_valid  plaintext byte available (FIFO non-empty)
//   out_data   plaintext byte at FIFO head
//   out_ready  consumer takes out_data this cycle
//   busy       high while in RUN or DRAIN
//   done       one-cycle pulse at end of message
//   byte_cnt   bytes accepted in current/last message
module caesar_stream_ctrl #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       key_in,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Three-layer Caesar decipher on one byte
  function automatic logic [7:0] decipher(input logic [7:0] c, input logic [7:0] k);
    logic [7:0] t3;
    logic [7:0] t2;
    logic [7:0] t1;
    t3 = c ^ k;
    t2 = t3 ^ (t3 >> 4);
    t1 = t2 - k;
    return t1 ^ k;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_key;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] w_remaining_nxt;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_start_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_in_ready_nxt;
  logic [7:0]       w_plain;

  // Handshakes; r_in_ready is only ever set while in RUN
  assign w_push  = in_valid && r_in_ready;
  assign w_pop   = r_out_valid && out_ready;
  assign w_plain = decipher(in_data, r_key);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and remaining-byte bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_start_acc     = 1'b0;
    w_remaining_nxt = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc     = 1'b1;
          w_remaining_nxt = msg_len;
          w_state_nxt     = (msg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_push) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (r_count == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // in_ready is registered from next-cycle state so a full FIFO blocks the same cycle
  assign w_in_ready_nxt = (w_state_nxt == ST_RUN) && (w_count_nxt != FIFO_FULL) &&
                          (w_remaining_nxt != '0);

  // Control registers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_remaining <= w_remaining_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done      <= (w_state_nxt == ST_DONE);
      if (w_start_acc) begin
        r_key      <= key_in;
        r_byte_cnt <= '0;
      end else if (w_push) begin
        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
`ifdef KEY_ROTATE_EN
        r_key      <= {r_key[6:0], r_key[7]};
`endif
      end
    end
  end

  // Output FIFO; storage is cleared on reset so out_data reads zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_plain;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign busy      = r_busy;
  assign done      = r_done;
  assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_caesar_stream_ctrl.sv
// Self-checking bench for caesar_stream_ctrl: directed and randomized messages
// against a transaction-level reference model (expected-plaintext queue,
// remaining/accepted counters, key tracked as an integer).
module tb_caesar_stream_ctrl;

  localparam int LEN_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       key_in;
  logic [LEN_W-1:0] msg_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_cnt;

  always #5 clk = ~clk;

  caesar_stream_ctrl #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .msg_len   (msg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .byte_cnt  (byte_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         rem;
  int         cnt;
  int         sent;
  int         mkey;
  bit         active;
  int         max_fill;
  int         cyc_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decipher computed with plain integer arithmetic
  function automatic logic [7:0] ref_plain(input int c, input int k);
    int t3;
    int t2;
    int t1;
    t3 = c ^ k;
    t2 = t3 ^ (t3 / 16);
    t1 = (t2 - k + 256) % 256;
    return 8'(t1 ^ k);
  endfunction

  // Called #1 after a rising edge; issues start for one cycle
  task automatic start_msg(input int key, input int len);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b1;
    key_in    = 8'(key);
    msg_len   = LEN_W'(len);
    @(posedge clk);
    rem      = len;
    cnt      = 0;
    sent     = 0;
    mkey     = key;
    active   = (len != 0);
    max_fill = 0;
    got.delete();
    #1;
    start   = 1'b0;
    key_in  = 8'($urandom);
    msg_len = LEN_W'($urandom);
  endtask

  // Runs cycles until done (or until abort_at bytes accepted), checking every cycle
  task automatic run_msg(input int hold, input int vpct, input int rpct, input int abort_at);
    int         cyc;
    bit         fin;
    bit         exp_rdy;
    bit         exp_vld;
    bit         acc;
    bit         pop;
    logic [7:0] popv;
    cyc      = 0;
    fin      = 1'b0;
    cyc_done = -1;
    popv     = 8'h00;
    while (!fin && cyc < 3000) begin
      in_valid  = (sent < src.size()) && (int'($urandom_range(99)) < vpct);
      in_data   = in_valid ? src[sent] : 8'($urandom);
      out_ready = (cyc >= hold) && (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      exp_rdy = (rem != 0) && (exp_q.size() < DEPTH);
      exp_vld = (exp_q.size() != 0);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) chk("out_data", 32'(out_data), 32'(exp_q[0]));
      chk("byte_cnt", 32'(byte_cnt), 32'(cnt));
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("done_fifo_empty", 32'(exp_q.size()), 32'(0));
        chk("done_all_accepted", 32'(rem), 32'(0));
        active   = 1'b0;
        fin      = 1'b1;
        cyc_done = cyc;
      end else begin
        chk("busy", 32'(busy), 32'(active));
      end
      acc  = in_valid && exp_rdy;
      pop  = exp_vld && out_ready;
      if (pop) popv = out_data;
      @(posedge clk);
      if (pop) begin
        got.push_back(popv);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(ref_plain(int'(in_data), mkey));
        rem--;
        cnt++;
        sent++;
`ifdef KEY_ROTATE_EN
        mkey = ((mkey << 1) | (mkey >> 7)) & 255;
`endif
      end
      if (exp_q.size() > max_fill) max_fill = exp_q.size();
      #1;
      cyc++;
      if (abort_at >= 0 && cnt == abort_at) fin = 1'b1;
    end
    chk("no_timeout", 32'(fin), 32'(1));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Cycle after done: pulse must be gone and controller idle
  task automatic post_done;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    key_in    = 8'h00;
    msg_len   = '0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rem       = 0;
    cnt       = 0;
    sent      = 0;
    mkey      = 0;
    active    = 1'b0;
    max_fill  = 0;
    cyc_done  = -1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: single byte, free-flowing consumer
    src = '{8'h12};
    start_msg(8'h03, 1);
    run_msg(0, 100, 100, -1);
    post_done();
    chk("t1_count", 32'(got.size()), 32'(1));
    chk("t1_plain", 32'(got[0]), 32'(8'h0E));

    // T2: zero key, two bytes in order
    src = '{8'h41, 8'h00};
    start_msg(8'h00, 2);
    run_msg(0, 100, 100, -1);
    post_done();
    chk("t2_count", 32'(got.size()), 32'(2));
    chk("t2_plain0", 32'(got[0]), 32'(8'h45));
    chk("t2_plain1", 32'(got[1]), 32'(8'h00));
    chk("t2_byte_cnt", 32'(byte_cnt), 32'(2));

    // T3: stalled consumer fills the FIFO, then drains
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    start_msg(int'($urandom_range(255)), 6);
    run_msg(12, 100, 80, -1);
    post_done();
    chk("t3_count", 32'(got.size()), 32'(6));
    chk("t3_max_fill", 32'(max_fill), 32'(DEPTH));

    // T4: empty message goes straight to DONE
    src.delete();
    start_msg(8'h5A, 0);
    run_msg(0, 100, 100, -1);
    chk("t4_done_latency", 32'(cyc_done), 32'(0));
    post_done();

    // T5: reset mid-RUN with two bytes buffered
    src.delete();
    for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
    start_msg(int'($urandom_range(255)), 5);
    run_msg(1000, 100, 0, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5");
    rst = 1'b0;
    exp_q.delete();
    rem    = 0;
    cnt    = 0;
    active = 1'b0;
    @(posedge clk);
    #1;

`ifdef KEY_ROTATE_EN
    // T6: rotating key across two bytes
    src = '{8'h00, 8'h00};
    start_msg(8'h81, 2);
    run_msg(0, 100, 100, -1);
    post_done();
    chk("t6_count", 32'(got.size()), 32'(2));
    chk("t6_plain0", 32'(got[0]), 32'(ref_plain(0, 8'h81)));
    chk("t6_plain1", 32'(got[1]), 32'(ref_plain(0, 8'h03)));
`endif

    // Randomized messages with random handshake pressure
    for (int m = 0; m < 10; m++) begin
      int len;
      len = int'($urandom_range(1, 20));
      src.delete();
      for (int i = 0; i < len; i++) src.push_back(8'($urandom));
      start_msg(int'($urandom_range(255)), len);
      run_msg(int'($urandom_range(0, 8)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), -1);
      post_done();
      chk("rand_count", 32'(got.size()), 32'(len));
      chk("rand_byte_cnt", 32'(byte_cnt), 32'(len));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
